// File: rtl/kf8237_pkg.sv
// rtl/kf8237_pkg.sv - shared widths, register word type and byte-load helper for the KF8237 register file
package kf8237_pkg;

  localparam int CHANNEL_W = 2;
  localparam int REG_W     = 16;

  typedef logic [REG_W-1:0] dma_word_t;

  function automatic dma_word_t load_byte(dma_word_t word, logic high, logic [7:0] data);
    return high ? {data, word[7:0]} : {word[15:8], data};
  endfunction

endpackage

// File: rtl/kf8237_address_and_count_registers_if.sv
// rtl/kf8237_address_and_count_registers_if.sv - strobe/data bundle between bus control, timing and the register file
interface kf8237_address_and_count_registers_if #(
  parameter int CHANNELS = 4
);

  logic [7:0]                       internal_data_bus;
  logic [CHANNELS-1:0]              write_base_and_current_address;
  logic [CHANNELS-1:0]              write_base_and_current_word_count;
  logic [CHANNELS-1:0]              read_current_address;
  logic [CHANNELS-1:0]              read_current_word_count;
  logic                             clear_byte_pointer;
  logic                             set_byte_pointer;
  logic                             master_clear;
  logic [kf8237_pkg::CHANNEL_W-1:0] dma_channel;
  logic                             dma_update;
  logic                             dma_address_decrement;
  logic                             dma_autoinitialize;
  logic [7:0]                       read_data;
  logic [kf8237_pkg::REG_W-1:0]     dma_current_address;
  logic                             terminal_count;
  logic                             byte_pointer;

  modport master (
    output internal_data_bus, write_base_and_current_address, write_base_and_current_word_count,
    output read_current_address, read_current_word_count, clear_byte_pointer, set_byte_pointer,
    output master_clear, dma_channel, dma_update, dma_address_decrement, dma_autoinitialize,
    input  read_data, dma_current_address, terminal_count, byte_pointer
  );

  modport slave (
    input  internal_data_bus, write_base_and_current_address, write_base_and_current_word_count,
    input  read_current_address, read_current_word_count, clear_byte_pointer, set_byte_pointer,
    input  master_clear, dma_channel, dma_update, dma_address_decrement, dma_autoinitialize,
    output read_data, dma_current_address, terminal_count, byte_pointer
  );

endinterface

// File: rtl/kf8237_channel_registers.sv
// rtl/kf8237_channel_registers.sv - base/current address and word count of one DMA channel
module kf8237_channel_registers
  import kf8237_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      i_master_clear,
  input  logic      i_byte_sel,
  input  logic [7:0] i_data,
  input  logic      i_write_address,
  input  logic      i_write_count,
  input  logic      i_update,
  input  logic      i_decrement,
  input  logic      i_reload,
  output dma_word_t o_current_address,
  output dma_word_t o_current_count
);

  dma_word_t r_base_address;
  dma_word_t r_current_address;
  dma_word_t r_base_count;
  dma_word_t r_current_count;
  dma_word_t w_next_address;
  dma_word_t w_next_count;

  assign w_next_address = i_decrement ? (r_current_address - 16'd1) : (r_current_address + 16'd1);
  assign w_next_count   = r_current_count - 16'd1;

  // The top suppresses i_update whenever this channel sees a CPU write, so the branches never collide.
  always_ff @(posedge clock) begin
    if (!reset_n || i_master_clear) begin
      r_base_address    <= '0;
      r_current_address <= '0;
      r_base_count      <= '0;
      r_current_count   <= '0;
    end else begin
      if (i_write_address) begin
        r_base_address    <= load_byte(r_base_address, i_byte_sel, i_data);
        r_current_address <= load_byte(r_current_address, i_byte_sel, i_data);
      end else if (i_update) begin
        r_current_address <= i_reload ? r_base_address : w_next_address;
      end
      if (i_write_count) begin
        r_base_count    <= load_byte(r_base_count, i_byte_sel, i_data);
        r_current_count <= load_byte(r_current_count, i_byte_sel, i_data);
      end else if (i_update) begin
        r_current_count <= i_reload ? r_base_count : w_next_count;
      end
    end
  end

  assign o_current_address = r_current_address;
  assign o_current_count   = r_current_count;

endmodule

// File: rtl/kf8237_address_and_count_registers.sv
// rtl/kf8237_address_and_count_registers.sv - per-channel register file, byte pointer, CPU read mux and terminal count
module kf8237_address_and_count_registers
  import kf8237_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input logic clock,
  input logic reset_n,
  kf8237_address_and_count_registers_if.slave bus
);

  logic [CHANNELS-1:0] w_wa_sel;
  logic [CHANNELS-1:0] w_wc_sel;
  logic [CHANNELS-1:0] w_write_ch;
  logic [CHANNELS-1:0] w_update_ch;
  logic [CHANNELS-1:0] w_reload_ch;
  dma_word_t           w_cur_address [CHANNELS];
  dma_word_t           w_cur_count   [CHANNELS];
  logic                w_update_eff;
  logic                w_count_zero;
  logic                w_write_any;
  logic                w_read_any;
  logic                w_read_fall;
  logic                w_read_hit;
  dma_word_t           w_read_word;
  logic                r_byte_pointer;
  logic                r_read_prev;
  logic                r_terminal_count;

  // Isolate the lowest set strobe bit so an illegal multi-bit strobe touches one channel only.
  assign w_wa_sel = bus.write_base_and_current_address
                  & (~bus.write_base_and_current_address + CHANNELS'(1));
  assign w_wc_sel = bus.write_base_and_current_word_count
                  & (~bus.write_base_and_current_word_count + CHANNELS'(1));
  assign w_write_ch  = w_wa_sel | w_wc_sel;
  assign w_write_any = |w_write_ch;

  assign w_update_eff = bus.dma_update & ~w_write_ch[bus.dma_channel];
  assign w_count_zero = (w_cur_count[bus.dma_channel] == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_update_ch[c] = w_update_eff && (bus.dma_channel == CHANNEL_W'(c));
    assign w_reload_ch[c] = bus.dma_autoinitialize && (w_cur_count[c] == '0);

    kf8237_channel_registers u_channel (
      .clock             (clock),
      .reset_n           (reset_n),
      .i_master_clear    (bus.master_clear),
      .i_byte_sel        (r_byte_pointer),
      .i_data            (bus.internal_data_bus),
      .i_write_address   (w_wa_sel[c]),
      .i_write_count     (w_wc_sel[c]),
      .i_update          (w_update_ch[c]),
      .i_decrement       (bus.dma_address_decrement),
      .i_reload          (w_reload_ch[c]),
      .o_current_address (w_cur_address[c]),
      .o_current_count   (w_cur_count[c])
    );
  end

  // Descending scan so the lowest strobed channel wins; address strobes outrank count strobes.
  always_comb begin
    w_read_word = '0;
    w_read_hit  = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.read_current_word_count[c]) begin
        w_read_word = w_cur_count[c];
        w_read_hit  = 1'b1;
      end
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.read_current_address[c]) begin
        w_read_word = w_cur_address[c];
        w_read_hit  = 1'b1;
      end
    end
  end

  assign w_read_any  = |{bus.read_current_address, bus.read_current_word_count};
  assign w_read_fall = r_read_prev & ~w_read_any;

  always_ff @(posedge clock) begin
    if (!reset_n || bus.master_clear) begin
      r_byte_pointer   <= 1'b0;
      r_read_prev      <= 1'b0;
      r_terminal_count <= 1'b0;
    end else begin
      r_read_prev      <= w_read_any;
      r_terminal_count <= w_update_eff & w_count_zero;
      if (bus.clear_byte_pointer) begin
        r_byte_pointer <= 1'b0;
      end else if (bus.set_byte_pointer) begin
        r_byte_pointer <= 1'b1;
      end else if (w_write_any || w_read_fall) begin
        r_byte_pointer <= ~r_byte_pointer;
      end
    end
  end

  assign bus.read_data           = w_read_hit ? (r_byte_pointer ? w_read_word[15:8] : w_read_word[7:0]) : 8'h00;
  assign bus.dma_current_address = w_cur_address[bus.dma_channel];
  assign bus.terminal_count      = r_terminal_count;
  assign bus.byte_pointer        = r_byte_pointer;

endmodule

// File: tb/tb_kf8237_address_and_count_registers.sv
// tb/tb_kf8237_address_and_count_registers.sv - table-driven bench for the KF8237 address/count register file
module tb_kf8237_address_and_count_registers;

  typedef struct {
    logic [3:0]  wa;
    logic [3:0]  wc;
    logic [3:0]  ra;
    logic [3:0]  rc;
    logic        clr;
    logic        setp;
    logic        mclr;
    logic [1:0]  ch;
    logic        upd;
    logic        dec;
    logic        ai;
    logic [7:0]  data;
    logic [7:0]  e_rd;
    logic [15:0] e_addr;
    logic        e_tc;
    logic        e_bp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  kf8237_address_and_count_registers_if #(.CHANNELS(4)) bus ();

  kf8237_address_and_count_registers #(.CHANNELS(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(
    input logic [3:0] wa, input logic [3:0] wc, input logic [3:0] ra, input logic [3:0] rc,
    input logic clr, input logic setp, input logic mclr, input logic [1:0] ch,
    input logic upd, input logic dec, input logic ai, input logic [7:0] data,
    input logic [7:0] e_rd, input logic [15:0] e_addr, input logic e_tc, input logic e_bp);
    vec_t t;
    t.wa = wa; t.wc = wc; t.ra = ra; t.rc = rc;
    t.clr = clr; t.setp = setp; t.mclr = mclr; t.ch = ch;
    t.upd = upd; t.dec = dec; t.ai = ai; t.data = data;
    t.e_rd = e_rd; t.e_addr = e_addr; t.e_tc = e_tc; t.e_bp = e_bp;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.write_base_and_current_address    = t.wa;
    bus.write_base_and_current_word_count = t.wc;
    bus.read_current_address              = t.ra;
    bus.read_current_word_count           = t.rc;
    bus.clear_byte_pointer                = t.clr;
    bus.set_byte_pointer                  = t.setp;
    bus.master_clear                      = t.mclr;
    bus.dma_channel                       = t.ch;
    bus.dma_update                        = t.upd;
    bus.dma_address_decrement             = t.dec;
    bus.dma_autoinitialize                = t.ai;
    bus.internal_data_bus                 = t.data;
  endtask

  task automatic check_outputs(input string tag, input vec_t t);
    check({tag, " read_data"},           {8'h00, bus.read_data}, {8'h00, t.e_rd});
    check({tag, " dma_current_address"}, bus.dma_current_address, t.e_addr);
    check({tag, " terminal_count"},      {15'd0, bus.terminal_count}, {15'd0, t.e_tc});
    check({tag, " byte_pointer"},        {15'd0, bus.byte_pointer}, {15'd0, t.e_bp});
  endtask

  initial begin
    // wa wc ra rc clr setp mclr ch upd dec ai data | rd addr tc bp
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,1,0,0,0,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h34, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h12, 8'h00,16'h0034,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,0));
    tbl.push_back(v(4'h0,4'h4,4'h0,4'h0,0,0,0,0,0,0,0,8'h03, 8'h00,16'h1234,0,0));
    tbl.push_back(v(4'h0,4'h4,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h4,0,0,0,0,0,0,0,8'h00, 8'h03,16'h1234,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h4,0,0,0,0,0,0,0,8'h00, 8'h03,16'h1234,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h4,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h1234,0,0));
    tbl.push_back(v(4'h2,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h2,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h10, 8'h00,16'h0000,0,1));
    tbl.push_back(v(4'h0,4'h2,4'h0,4'h0,0,0,0,1,0,0,0,8'h01, 8'h00,16'h1000,0,0));
    tbl.push_back(v(4'h0,4'h2,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,1,0,0,8'h00, 8'h00,16'h1000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,1,0,0,8'h00, 8'h00,16'h1001,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h2,0,0,0,1,0,0,0,8'h00, 8'hFF,16'h1002,1,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1002,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h2,0,0,0,1,0,0,0,8'h00, 8'hFF,16'h1002,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1002,0,1));
    tbl.push_back(v(4'h8,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h8,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h20, 8'h00,16'h0000,0,1));
    tbl.push_back(v(4'h0,4'h8,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,0,0));
    tbl.push_back(v(4'h0,4'h8,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,1,1,1,8'h00, 8'h00,16'h2000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h8,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,1,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h8,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h2000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,1,1,0,8'h00, 8'h00,16'h2000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h1FFF,1,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,1,1,1,8'h00, 8'h00,16'h1FFF,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,3,0,0,0,8'h00, 8'h00,16'h1FFE,0,0));
    tbl.push_back(v(4'h0,4'h2,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1002,0,0));
    tbl.push_back(v(4'h0,4'h2,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1002,0,1));
    tbl.push_back(v(4'h2,4'h0,4'h0,4'h0,0,0,0,1,1,0,0,8'h55, 8'h00,16'h1002,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1055,0,1));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,0,1,1,0,0,8'hAA, 8'h00,16'h1055,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h1,4'h0,0,0,0,1,0,0,0,8'h00, 8'h34,16'h1056,1,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1056,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h1,4'h0,0,0,0,1,0,0,0,8'h00, 8'hAA,16'h1056,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h1056,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,1,0,0,0,0,0,8'h00, 8'h00,16'hAA34,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,1,1,0,0,0,0,0,8'h00, 8'h00,16'hAA34,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'hAA34,0,0));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,1,0,0,0,0,0,8'h77, 8'h00,16'hAA34,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'hAA77,0,1));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,1,0,0,0,0,0,8'h88, 8'h00,16'hAA77,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h8877,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,1,0,0,0,0,0,0,8'h00, 8'h00,16'h8877,0,1));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h11, 8'h00,16'h8877,0,0));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,1,0,1,0,0,8'h99, 8'h00,16'h8811,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h1,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h5A, 8'h00,16'h0000,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h005A,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,2,1,1,0,8'h00, 8'h00,16'h0000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,2,0,0,0,8'h00, 8'h00,16'hFFFF,1,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,2,1,0,0,8'h00, 8'h00,16'hFFFF,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,2,0,0,0,8'h00, 8'h00,16'h0000,0,1));
    tbl.push_back(v(4'h6,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h3C, 8'h00,16'h0000,0,1));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h3C00,0,0));
    tbl.push_back(v(4'h0,4'h0,4'h0,4'h0,0,0,0,2,0,0,0,8'h00, 8'h00,16'h0000,0,0));

    reset_n = 1'b0;
    drive(v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs("reset", v(4'h0,4'h0,4'h0,4'h0,0,0,0,0,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clock);
      check_outputs($sformatf("row%0d", i), tbl[i]);
      @(posedge clock);
      #1;
    end

    // Mid-run reset beats a simultaneous CPU write and clears a set byte pointer.
    drive(v(4'h0,4'h0,4'h0,4'h0,0,1,0,1,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    @(posedge clock);
    #1;
    check("pre_reset byte_pointer", {15'd0, bus.byte_pointer}, 16'h0001);
    reset_n = 1'b0;
    drive(v(4'h2,4'h0,4'h0,4'h0,0,0,0,1,1,0,0,8'h77, 8'h00,16'h0000,0,0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(v(4'h0,4'h0,4'h0,4'h0,0,0,0,1,0,0,0,8'h00, 8'h00,16'h0000,0,0));
    @(negedge clock);
    check("post_reset dma_current_address", bus.dma_current_address, 16'h0000);
    check("post_reset byte_pointer", {15'd0, bus.byte_pointer}, 16'h0000);
    check("post_reset terminal_count", {15'd0, bus.terminal_count}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
